// File: rtl/ifstmt_deser.sv
// Serial-to-parallel deserializer: a start bit followed by WIDTH data bits (and an
// optional even-parity bit when IFSTMT_DESER_PARITY_EN is defined) produces one word.
module ifstmt_deser #(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_clear,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

`ifdef IFSTMT_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  shnext;
    logic              count_clr;
    logic              count_inc;
    logic              shift_en;
    logic              load_word;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shnext = {shreg[WIDTH-2:0], sin_data};
        end else begin : g_lsb
            assign shnext = {sin_data, shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        count_clr  = 1'b0;
        count_inc  = 1'b0;
        shift_en   = 1'b0;
        load_word  = 1'b0;
        case (state)
            IDLE: begin
                if (sin_valid && sin_data) begin
                    next_state = SHIFT;
                    count_clr  = 1'b1;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    shift_en  = 1'b1;
                    count_inc = 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
`ifdef IFSTMT_DESER_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = DONE;
                        load_word  = 1'b1;
`endif
                    end
                end
            end
`ifdef IFSTMT_DESER_PARITY_EN
            PARITY: begin
                if (sin_valid) begin
                    next_state = DONE;
                    load_word  = 1'b1;
                end
            end
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // Abort wins over everything, including a frame completing on this cycle.
        if (sin_clear) begin
            next_state = IDLE;
            count_clr  = 1'b1;
            count_inc  = 1'b0;
            shift_en   = 1'b0;
            load_word  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            if (count_clr)      count <= '0;
            else if (count_inc) count <= count + 1'b1;
            if (shift_en) shreg <= shnext;
            word_valid <= load_word;
`ifdef IFSTMT_DESER_PARITY_EN
            if (load_word) word <= shreg;
`else
            // The last data bit is still on sin_data, so capture the shifted value.
            if (load_word) word <= shnext;
`endif
        end
    end

`ifdef IFSTMT_DESER_PARITY_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= load_word & ((^shreg) ^ sin_data);
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: doc/ifstmt_deser.md
IFSTMT_DESER -- requirements
Module: ifstmt_deser

Interface
REQ-001 Parameter WIDTH, default 32: deserialized word width, legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: bit order; 1 means the first data bit is the word MSB, 0 means it is the LSB. Selected by a generate-if on the constant.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sin_valid  input  1  sin_data is sampled on this cycle.
REQ-006 sin_data  input  1  serial bit.
REQ-007 sin_clear  input  1  synchronous frame abort.
REQ-008 word  output  WIDTH  assembled word, registered.
REQ-009 word_valid  output  1  one-cycle pulse; word is valid on that cycle.
REQ-010 err  output  1  parity error flag, qualified by word_valid.
REQ-011 busy  output  1  high in every state other than IDLE.

Function
REQ-012 FSM states: IDLE, SHIFT, PARITY, DONE.
REQ-013 IDLE:
- sin_valid=1 with sin_data=1 is the start bit; go to SHIFT with bit count 0.
- sin_valid=1 with sin_data=0 is ignored.
REQ-014 SHIFT:
- Each sin_valid cycle accepts one data bit and increments the count.
- Cycles with sin_valid=0 hold all state; gaps of any length are allowed.
REQ-015 Bit placement:
- MSB_FIRST=1: shift left, new bit enters bit 0.
- MSB_FIRST=0: shift right, new bit enters bit WIDTH-1.
REQ-016 The count is $clog2(WIDTH)+1 bits wide. After the WIDTH-th bit is accepted, go to PARITY if parity is compiled in, otherwise go to DONE.
REQ-017 PARITY: the next sin_valid bit is the parity bit; go to DONE.
REQ-018 DONE lasts exactly one cycle, then returns to IDLE.
- word_valid=1 and word holds the assembled value.
- Bits presented with sin_valid=1 during DONE are dropped, including a start bit.
REQ-019 Latency: word_valid asserts on the cycle after the final accepted bit. The final bit is the parity bit when parity is compiled in, otherwise data bit WIDTH.
REQ-020 word holds its last value until the next DONE and is not cleared on IDLE.
REQ-021 sin_clear=1 in any state goes to IDLE next cycle with count 0. No word_valid is generated. sin_clear has priority over sin_valid on the same cycle.
REQ-022 sin_clear in DONE: word_valid still pulses on that cycle, and the next state is IDLE.

Reset
REQ-023 While rst_n=0: state=IDLE, count=0, shift register=0, word=0, word_valid=0, err=0, busy=0.
REQ-024 Reset assertion mid-frame discards the partial frame immediately. After reset release, the first valid cycle is treated as IDLE.

Configuration
REQ-025 Macro IFSTMT_DESER_PARITY_EN:
- Defined: the PARITY state exists and the frame is start + WIDTH data bits + one even-parity bit. err=1 on word_valid when the XOR of the data bits and the parity bit is 1.
- Undefined: the PARITY state is absent and the frame is start + WIDTH data bits. err is tied to 0.

Verification
REQ-026 Default parameters, macro undefined: start, then 0xDEADBEEF MSB-first on 32 consecutive valid cycles -> word=0xDEADBEEF, word_valid high exactly one cycle, on the cycle after bit 32.
REQ-027 MSB_FIRST=0, WIDTH=8: start, then bits 1,0,0,0,0,0,0,0 -> word=0x01, err=0.
REQ-028 Macro defined, WIDTH=32: start, 0xDEADBEEF, parity 0 -> err=0. Repeat with parity 1 -> err=1. word=0xDEADBEEF in both cases.
REQ-029 Gaps: random sin_valid=0 gaps of 0..5 cycles between bits of 0xA5A5A5A5 -> same word as the gap-free run. Leading sin_data=0 valid bits in IDLE -> ignored.
REQ-030 Abort cases:
- sin_clear after 10 data bits, then a full frame of 0x12345678 -> only 0x12345678 is reported.
- rst_n pulsed low mid-frame -> all outputs 0, busy=0.
- Start bit sent in the DONE cycle -> dropped and busy=0 on the following cycle.
